// File: rtl/writeback_arbiter_pkg.sv
// Shared CPU constants and the writeback payload record used by the arbiter
// and its load-result buffer.
package writeback_arbiter_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  localparam int WB_ENTRY_W = $bits(wb_entry_t);

  // One-hot register mask; x0 never maps to a bit so it can never be busy.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
    reg_onehot = '0;
    if (r != '0) reg_onehot[r] = 1'b1;
  endfunction

endpackage

// File: rtl/writeback_arbiter_fifo.sv
// Small in-order buffer for load results; pointers carry one extra wrap bit
// so full and empty are distinguishable without a separate counter.
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
  input  logic             I_push,
  input  logic [WIDTH-1:0] I_data,
  input  logic             I_pop,
  output logic [WIDTH-1:0] O_data,
  output logic             O_full,
  output logic             O_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign O_empty = (wr_ptr == rd_ptr);
  assign O_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_push = I_push && !O_full;
  assign do_pop  = I_pop && !O_empty;
  assign O_data  = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Storage needs no reset: entries are only visible between push and pop.
  always_ff @(posedge I_clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= I_data;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Single-port writeback arbiter: merges ALU and buffered load results into the
// register file and keeps the pending-write scoreboard that drives issue stalls.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int LSU_FIFO_DEPTH = 2
) (
  input  logic                  I_clk,
  input  logic                  I_rst_n,
  input  logic                  I_alu_valid,
  input  logic [REG_ADDR_W-1:0] I_alu_rd,
  input  logic [XLEN-1:0]       I_alu_data,
  output logic                  O_alu_ready,
  input  logic                  I_lsu_valid,
  input  logic [REG_ADDR_W-1:0] I_lsu_rd,
  input  logic [XLEN-1:0]       I_lsu_data,
  output logic                  O_lsu_ready,
  input  logic                  I_issue_valid,
  input  logic [REG_ADDR_W-1:0] I_issue_rs1,
  input  logic [REG_ADDR_W-1:0] I_issue_rs2,
  input  logic [REG_ADDR_W-1:0] I_issue_rd,
  output logic                  O_hazard,
  output logic                  O_rf_we,
  output logic [REG_ADDR_W-1:0] O_rf_rd,
  output logic [XLEN-1:0]       O_rf_data,
  output logic [NUM_REGS-1:0]   O_busy
);

  wb_entry_t               lsu_entry;
  wb_entry_t               head_entry;
  wb_entry_t               sel_entry;
  logic [WB_ENTRY_W-1:0]   head_bits;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    sel_valid;
  logic [NUM_REGS-1:0]     busy_q;
  logic [NUM_REGS-1:0]     set_mask;
  logic [NUM_REGS-1:0]     clr_mask;

  assign lsu_entry   = '{rd: I_lsu_rd, data: I_lsu_data};
  assign head_entry  = wb_entry_t'(head_bits);
  assign O_lsu_ready = !fifo_full;
  assign O_alu_ready = !fifo_full;
  assign fifo_push   = I_lsu_valid && !fifo_full;

  wb_fifo #(
    .WIDTH (WB_ENTRY_W),
    .DEPTH (LSU_FIFO_DEPTH)
  ) u_lsu_fifo (
    .I_clk   (I_clk),
    .I_rst_n (I_rst_n),
    .I_push  (fifo_push),
    .I_data  (lsu_entry),
    .I_pop   (fifo_pop),
    .O_data  (head_bits),
    .O_full  (fifo_full),
    .O_empty (fifo_empty)
  );

  // A full buffer drains first so the load path can never deadlock behind ALU traffic.
  always_comb begin
    sel_valid = 1'b0;
    sel_entry = '0;
    fifo_pop  = 1'b0;
    if (fifo_full) begin
      sel_valid = 1'b1;
      sel_entry = head_entry;
      fifo_pop  = 1'b1;
    end else if (I_alu_valid) begin
      sel_valid = 1'b1;
      sel_entry = '{rd: I_alu_rd, data: I_alu_data};
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      sel_entry = head_entry;
      fifo_pop  = 1'b1;
    end
  end

  // Writes to x0 are consumed but never reach the register file.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_rf_we   <= 1'b0;
      O_rf_rd   <= '0;
      O_rf_data <= '0;
    end else if (sel_valid && sel_entry.rd != '0) begin
      O_rf_we   <= 1'b1;
      O_rf_rd   <= sel_entry.rd;
      O_rf_data <= sel_entry.data;
    end else begin
      O_rf_we   <= 1'b0;
      O_rf_rd   <= '0;
      O_rf_data <= '0;
    end
  end

  assign O_hazard = I_issue_valid &&
                    ((I_issue_rs1 != '0 && busy_q[I_issue_rs1]) ||
                     (I_issue_rs2 != '0 && busy_q[I_issue_rs2]) ||
                     (I_issue_rd  != '0 && busy_q[I_issue_rd]));

  assign set_mask = (I_issue_valid && !O_hazard) ? reg_onehot(I_issue_rd) : '0;
  assign clr_mask = O_rf_we ? reg_onehot(O_rf_rd) : '0;

  // Clears line up with the register-file capture edge of the registered write.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) busy_q <= '0;
    else          busy_q <= (busy_q & ~clr_mask) | set_mask;
  end

  assign O_busy = busy_q;

  a_no_set_clr_overlap: assert property (@(posedge I_clk) disable iff (!I_rst_n)
    (set_mask & clr_mask) == '0);

endmodule
